// File: rtl/trisc_pkg.sv
`default_nettype none
// ============================================================================
// Module      : trisc_pkg
// Description : Shared opcode values, control-state encoding and the
//               "opcode needs an operand read" decode for the TRISC core.
// Revision    : 1.0  initial parametrised release
// ============================================================================
package trisc_pkg;

    localparam logic [3:0] OP_NOP = 4'h0;
    localparam logic [3:0] OP_LDA = 4'h1;
    localparam logic [3:0] OP_STA = 4'h2;
    localparam logic [3:0] OP_ADD = 4'h3;
    localparam logic [3:0] OP_SUB = 4'h4;
    localparam logic [3:0] OP_AND = 4'h5;
    localparam logic [3:0] OP_XOR = 4'h6;
    localparam logic [3:0] OP_LDI = 4'h7;
    localparam logic [3:0] OP_JMP = 4'h8;
    localparam logic [3:0] OP_JZ  = 4'h9;
    localparam logic [3:0] OP_JC  = 4'hA;
    localparam logic [3:0] OP_INC = 4'hB;
    localparam logic [3:0] OP_HLT = 4'hF;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_FETCH  = 3'd1,
        ST_DECODE = 3'd2,
        ST_READ   = 3'd3,
        ST_EXEC   = 3'd4
    } state_t;

    // Opcodes whose second operand comes from RAM need the extra READ cycle.
    function automatic logic needs_read(input logic [3:0] op);
        return (op == OP_LDA) || (op == OP_ADD) || (op == OP_SUB) ||
               (op == OP_AND) || (op == OP_XOR);
    endfunction

endpackage
`default_nettype wire

// File: rtl/trisc_alu.sv
`default_nettype none
// ============================================================================
// Module      : trisc_alu
// Description : Combinational accumulator ALU. Produces the new accumulator
//               value plus carry/borrow and signed-overflow indications.
// Revision    : 1.0  initial parametrised release
// ============================================================================
module trisc_alu
    import trisc_pkg::*;
#(
    parameter int W = 4
) (
    input  logic [W-1:0] acc_i,
    input  logic [W-1:0] opnd_i,
    input  logic [3:0]   opcode_i,
    output logic [W-1:0] result_o,
    output logic         carry_o,
    output logic         overflow_o
);

    logic [W:0] w_sum;
    logic [W:0] w_diff;
    logic [W:0] w_inc;

    // One extra bit on each result exposes carry out / borrow directly.
    assign w_sum  = {1'b0, acc_i} + {1'b0, opnd_i};
    assign w_diff = {1'b0, acc_i} - {1'b0, opnd_i};
    assign w_inc  = {1'b0, acc_i} + {{W{1'b0}}, 1'b1};

    // Select the result and flag outputs for the current opcode.
    always_comb begin
        result_o   = acc_i;
        carry_o    = 1'b0;
        overflow_o = 1'b0;
        case (opcode_i)
            OP_LDA, OP_LDI: result_o = opnd_i;
            OP_ADD: begin
                result_o   = w_sum[W-1:0];
                carry_o    = w_sum[W];
                overflow_o = (acc_i[W-1] == opnd_i[W-1]) && (w_sum[W-1] != acc_i[W-1]);
            end
            OP_SUB: begin
                result_o   = w_diff[W-1:0];
                carry_o    = w_diff[W];
                overflow_o = (acc_i[W-1] != opnd_i[W-1]) && (w_diff[W-1] != acc_i[W-1]);
            end
            OP_AND: result_o = acc_i & opnd_i;
            OP_XOR: result_o = acc_i ^ opnd_i;
            OP_INC: begin
                result_o   = w_inc[W-1:0];
                carry_o    = w_inc[W];
                overflow_o = !acc_i[W-1] && w_inc[W-1];
            end
            default: ;
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/trisc_core.sv
`default_nettype none
// ============================================================================
// Module      : trisc_core
// Description : Parametrised TRISC accumulator machine: PC, IR, ACC, flags,
//               fetch/decode/read/exec control and single-port program/data
//               RAM with a front-panel load mode.
//               Optional macro TRISC_STEP_EN: FETCH waits for a Step pulse.
// Revision    : 1.0  initial parametrised release
// ============================================================================
module trisc_core
    import trisc_pkg::*;
#(
    parameter int W = 4
) (
    input  logic           SysClock,
    input  logic           StartStop,
    input  logic           Mode,
    input  logic           Run,
    input  logic           Step,
    input  logic           LoadStrobe,
    input  logic           ClearAddGen,
    input  logic [W+3:0]   LoadData,
    output logic [W-1:0]   Pc,
    output logic [3:0]     Ir,
    output logic [W-1:0]   Acc,
    output logic           FlagZ,
    output logic           FlagC,
    output logic           FlagV,
    output logic           Busy,
    output logic           Halted,
    output logic [W-1:0]   LoadAddr,
    output logic [W+3:0]   MemQ
);

    localparam logic [W-1:0] c_one = {{(W-1){1'b0}}, 1'b1};

    state_t         state_q;
    logic [W-1:0]   pc_q, acc_q, opnd_q, laddr_q;
    logic [3:0]     ir_q;
    logic           z_q, c_q, v_q, halted_q;
    logic [W+3:0]   memq_q;
    logic [W+3:0]   mem_q [0:(1<<W)-1];

    logic [W-1:0]   w_ram_addr;
    logic           w_ram_we;
    logic [W+3:0]   w_ram_wdata;
    logic [W-1:0]   w_alu_b, w_alu_res;
    logic           w_alu_c, w_alu_v;
    logic           w_acc_we, w_flag_we;
    logic           w_fetch_go;

`ifdef TRISC_STEP_EN
    assign w_fetch_go = Step;
`else
    logic w_unused_step;
    assign w_fetch_go    = 1'b1;
    assign w_unused_step = Step;
`endif

    // Memory operands arrive through MemQ; immediates and targets use the operand field.
    assign w_alu_b = needs_read(ir_q) ? memq_q[W-1:0] : opnd_q;

    trisc_alu #(.W(W)) u_alu (
        .acc_i      (acc_q),
        .opnd_i     (w_alu_b),
        .opcode_i   (ir_q),
        .result_o   (w_alu_res),
        .carry_o    (w_alu_c),
        .overflow_o (w_alu_v)
    );

    // RAM port steering: load address in IDLE, operand in READ/EXEC, else PC.
    always_comb begin
        w_ram_addr  = pc_q;
        w_ram_we    = 1'b0;
        w_ram_wdata = LoadData;
        case (state_q)
            ST_IDLE: begin
                w_ram_addr = laddr_q;
                w_ram_we   = Mode && LoadStrobe && !ClearAddGen;
            end
            ST_READ: w_ram_addr = opnd_q;
            ST_EXEC: begin
                w_ram_addr  = opnd_q;
                w_ram_we    = (ir_q == OP_STA);
                w_ram_wdata = {4'b0000, acc_q};
            end
            default: ;
        endcase
    end

    // Which opcodes write the accumulator, and which of those also update C/V.
    always_comb begin
        w_acc_we  = 1'b0;
        w_flag_we = 1'b0;
        case (ir_q)
            OP_LDA, OP_AND, OP_XOR, OP_LDI: w_acc_we = 1'b1;
            OP_ADD, OP_SUB, OP_INC: begin
                w_acc_we  = 1'b1;
                w_flag_we = 1'b1;
            end
            default: ;
        endcase
    end

    // RAM array write port; contents deliberately survive reset.
    always_ff @(posedge SysClock) begin
        if (w_ram_we) begin
            mem_q[w_ram_addr] <= w_ram_wdata;
        end
    end

    // Control FSM with all architectural registers and the registered read port.
    always_ff @(posedge SysClock or negedge StartStop) begin
        if (!StartStop) begin
            state_q  <= ST_IDLE;
            pc_q     <= '0;
            ir_q     <= '0;
            acc_q    <= '0;
            opnd_q   <= '0;
            z_q      <= 1'b0;
            c_q      <= 1'b0;
            v_q      <= 1'b0;
            halted_q <= 1'b0;
            laddr_q  <= '0;
            memq_q   <= '0;
        end else begin
            memq_q <= mem_q[w_ram_addr];
            case (state_q)
                ST_IDLE: begin
                    if (Mode) begin
                        if (ClearAddGen) begin
                            laddr_q <= '0;
                        end else if (LoadStrobe) begin
                            laddr_q <= laddr_q + c_one;
                        end
                    end else if (Run) begin
                        state_q  <= ST_FETCH;
                        halted_q <= 1'b0;
                    end
                end
                ST_FETCH: begin
                    if (w_fetch_go) begin
                        state_q <= ST_DECODE;
                    end
                end
                ST_DECODE: begin
                    ir_q    <= memq_q[W+3:W];
                    opnd_q  <= memq_q[W-1:0];
                    pc_q    <= pc_q + c_one;
                    state_q <= needs_read(memq_q[W+3:W]) ? ST_READ : ST_EXEC;
                end
                ST_READ: state_q <= ST_EXEC;
                ST_EXEC: begin
                    state_q <= ST_FETCH;
                    if (w_acc_we) begin
                        acc_q <= w_alu_res;
                        z_q   <= (w_alu_res == '0);
                    end
                    if (w_flag_we) begin
                        c_q <= w_alu_c;
                        v_q <= w_alu_v;
                    end
                    case (ir_q)
                        OP_JMP: pc_q <= opnd_q;
                        OP_JZ:  if (z_q) pc_q <= opnd_q;
                        OP_JC:  if (c_q) pc_q <= opnd_q;
                        OP_HLT: begin
                            state_q  <= ST_IDLE;
                            halted_q <= 1'b1;
                        end
                        default: ;
                    endcase
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign Pc       = pc_q;
    assign Ir       = ir_q;
    assign Acc      = acc_q;
    assign FlagZ    = z_q;
    assign FlagC    = c_q;
    assign FlagV    = v_q;
    assign Busy     = (state_q != ST_IDLE);
    assign Halted   = halted_q;
    assign LoadAddr = laddr_q;
    assign MemQ     = memq_q;

endmodule
`default_nettype wire

// File: tb/tb_trisc_core.sv
`default_nettype none
// ============================================================================
// Module      : tb_trisc_core
// Description : Scoreboard bench for trisc_core (W=4). An instruction-level
//               model predicts the state at each HLT; a monitor compares when
//               Busy drops with Halted set, and checks RAM dumps via MemQ.
//               Honours TRISC_STEP_EN for the single-step scenario.
// Revision    : 1.0  initial release
// ============================================================================
module tb_trisc_core;

    localparam int W = 4;

    logic           SysClock = 1'b0;
    logic           StartStop = 1'b0;
    logic           Mode = 1'b0, Run = 1'b0, LoadStrobe = 1'b0, ClearAddGen = 1'b0;
    logic [W+3:0]   LoadData = '0;
    logic           step_man = 1'b0;
`ifdef TRISC_STEP_EN
    logic           step_auto = 1'b1;
`else
    logic           step_auto = 1'b0;
`endif
    logic           Step;
    logic [W-1:0]   Pc, Acc, LoadAddr;
    logic [3:0]     Ir;
    logic           FlagZ, FlagC, FlagV, Busy, Halted;
    logic [W+3:0]   MemQ;

    assign Step = step_auto | step_man;
    always #5 SysClock = ~SysClock;

    trisc_core #(.W(W)) dut (
        .SysClock(SysClock), .StartStop(StartStop), .Mode(Mode), .Run(Run),
        .Step(Step), .LoadStrobe(LoadStrobe), .ClearAddGen(ClearAddGen),
        .LoadData(LoadData), .Pc(Pc), .Ir(Ir), .Acc(Acc), .FlagZ(FlagZ),
        .FlagC(FlagC), .FlagV(FlagV), .Busy(Busy), .Halted(Halted),
        .LoadAddr(LoadAddr), .MemQ(MemQ)
    );

    int n_chk = 0, n_fail = 0;

    function automatic void chk(string name, int act, int exp);
        n_chk++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endfunction

    function automatic void fail_now(string name);
        n_chk++;
        n_fail++;
        $display("FAIL %s (t=%0t)", name, $time);
    endfunction

    // ---------------- instruction-level reference model ----------------
    int m_mem [16];
    int m_pc = 0, m_acc = 0;
    bit m_z = 0, m_c = 0, m_v = 0;
    int bk_mem [16];
    int bk_pc, bk_acc;
    bit bk_z, bk_c, bk_v;

    function automatic int sgn(int x);
        return (x >= 8) ? x - 16 : x;
    endfunction

    // Executes one instruction; returns its cycle count.
    function automatic int exec_one(output bit hlt);
        int op, opd, m, r, s;
        op  = m_mem[m_pc] / 16;
        opd = m_mem[m_pc] % 16;
        m   = m_mem[opd] % 16;
        m_pc = (m_pc + 1) % 16;
        hlt = 0;
        case (op)
            1: begin m_acc = m; m_z = (m_acc == 0); return 4; end
            2: begin m_mem[opd] = m_acc; return 3; end
            3, 4, 11: begin
                if (op == 11) m = 1;
                if (op == 4) begin
                    r = m_acc - m;  s = sgn(m_acc) - sgn(m);  m_c = (r < 0);
                end else begin
                    r = m_acc + m;  s = sgn(m_acc) + sgn(m);  m_c = (r > 15);
                end
                m_v = (s > 7) || (s < -8);
                m_acc = (r + 16) % 16;
                m_z = (m_acc == 0);
                return (op == 11) ? 3 : 4;
            end
            5: begin m_acc = m_acc & m; m_z = (m_acc == 0); return 4; end
            6: begin m_acc = m_acc ^ m; m_z = (m_acc == 0); return 4; end
            7: begin m_acc = opd; m_z = (m_acc == 0); return 3; end
            8: begin m_pc = opd; return 3; end
            9: begin if (m_z) m_pc = opd; return 3; end
            10: begin if (m_c) m_pc = opd; return 3; end
            15: begin hlt = 1; return 3; end
            default: return 3;
        endcase
    endfunction

    function automatic void model_reset();
        m_pc = 0; m_acc = 0; m_z = 0; m_c = 0; m_v = 0;
    endfunction

    function automatic bit model_halts(input int img [16]);
        bit h = 0;
        int n = 0, cy;
        bk_mem = m_mem; bk_pc = m_pc; bk_acc = m_acc; bk_z = m_z; bk_c = m_c; bk_v = m_v;
        m_mem = img;
        while (!h && n < 60) begin cy = exec_one(h); n++; end
        m_mem = bk_mem; m_pc = bk_pc; m_acc = bk_acc; m_z = bk_z; m_c = bk_c; m_v = bk_v;
        return h;
    endfunction

    // ---------------- scoreboard ----------------
    typedef struct {
        int pc; int acc; bit z; bit c; bit v; int cyc;
    } exp_t;
    exp_t sb_q [$];
    int   pk_q [$];
    logic peek_now = 1'b0;

    // Monitor: compares at HLT completion and on RAM peeks.
    initial begin
        int bc = 0;
        bit pb = 0;
        exp_t e;
        forever begin
            @(negedge SysClock);
            if (peek_now) begin
                if (pk_q.size() == 0) fail_now("peek_underflow");
                else chk("mem_word", int'(MemQ), pk_q.pop_front());
            end
            if (Busy) begin
                bc = pb ? bc + 1 : 1;
            end else if (pb && Halted) begin
                if (sb_q.size() == 0) begin
                    fail_now("unexpected_halt");
                end else begin
                    e = sb_q.pop_front();
                    chk("halt_pc", int'(Pc), e.pc);
                    chk("halt_acc", int'(Acc), e.acc);
                    chk("halt_z", int'(FlagZ), int'(e.z));
                    chk("halt_c", int'(FlagC), int'(e.c));
                    chk("halt_v", int'(FlagV), int'(e.v));
                    chk("halt_ir", int'(Ir), 15);
                    if (e.cyc != 0) chk("busy_cycles", bc, e.cyc);
                end
            end
            pb = Busy;
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic tick(input int n = 1);
        repeat (n) @(posedge SysClock);
        #1;
    endtask

    task automatic chk_reset(input string tag);
        chk({tag, "_pc"}, int'(Pc), 0);
        chk({tag, "_acc"}, int'(Acc), 0);
        chk({tag, "_ir"}, int'(Ir), 0);
        chk({tag, "_flags"}, int'({FlagZ, FlagC, FlagV}), 0);
        chk({tag, "_busy"}, int'(Busy), 0);
        chk({tag, "_halted"}, int'(Halted), 0);
        chk({tag, "_laddr"}, int'(LoadAddr), 0);
        chk({tag, "_memq"}, int'(MemQ), 0);
    endtask

    task automatic reset_dut();
        StartStop = 1'b0; tick(); StartStop = 1'b1; tick();
        model_reset();
    endtask

    task automatic load_mem(input int img [16]);
        Mode = 1'b1; ClearAddGen = 1'b1; tick(); ClearAddGen = 1'b0;
        for (int a = 0; a < 16; a++) begin
            LoadStrobe = 1'b1; LoadData = 8'(img[a]); m_mem[a] = img[a]; tick();
        end
        LoadStrobe = 1'b0; Mode = 1'b0;
        chk("load_wrap_addr", int'(LoadAddr), 0);
    endtask

    // Reads every RAM word through MemQ, writing back the expected value.
    task automatic dump_check();
        Mode = 1'b1; ClearAddGen = 1'b1; tick(); ClearAddGen = 1'b0;
        for (int a = 0; a < 16; a++) begin
            tick();
            pk_q.push_back(m_mem[a]);
            peek_now = 1'b1; LoadStrobe = 1'b1; LoadData = 8'(m_mem[a]);
            tick();
            peek_now = 1'b0; LoadStrobe = 1'b0;
        end
        Mode = 1'b0;
        chk("dump_wrap_addr", int'(LoadAddr), 0);
    endtask

    task automatic push_expect(input bit chk_cyc);
        exp_t e;
        bit h = 0;
        int cyc = 0, n = 0;
        while (!h && n < 200) begin cyc += exec_one(h); n++; end
        e.pc = m_pc; e.acc = m_acc; e.z = m_z; e.c = m_c; e.v = m_v;
        e.cyc = chk_cyc ? cyc : 0;
        sb_q.push_back(e);
    endtask

    task automatic wait_empty(input int budget);
        int n = 0;
        while (sb_q.size() != 0 && n < budget) begin tick(); n++; end
        if (sb_q.size() != 0) begin
            fail_now("halt_timeout");
            sb_q.delete();
            reset_dut();
        end
        tick(2);
    endtask

    task automatic run_prog(input bit chk_cyc);
        push_expect(chk_cyc);
        Mode = 1'b0; Run = 1'b1; tick(); Run = 1'b0;
        wait_empty(1000);
    endtask

    // ---------------- main sequence ----------------
    initial begin
        int img [16];
        int br_seq [4];
        int last, k, p, d, r, op;
        bit ok;
        br_seq = '{1, 2, 3, 0};

        tick(2);
        chk_reset("por");
        StartStop = 1'b1; tick();

        // Load mode: sequential writes, then clear beats strobe.
        Mode = 1'b1; ClearAddGen = 1'b1; tick(); ClearAddGen = 1'b0;
        LoadStrobe = 1'b1;
        LoadData = 8'h7A; tick();
        LoadData = 8'h1F; tick();
        LoadData = 8'hF0; tick();
        LoadStrobe = 1'b0;
        chk("ld_addr3", int'(LoadAddr), 3);
        ClearAddGen = 1'b1; LoadStrobe = 1'b1; LoadData = 8'h55; tick();
        ClearAddGen = 1'b0; LoadStrobe = 1'b0;
        chk("ld_clear_addr", int'(LoadAddr), 0);
        tick();
        chk("ld_nowrite_m0", int'(MemQ), 8'h7A);
        Mode = 1'b0;

        // Branch loop: LDI F / INC / JZ 0 never halts.
        img = '{default: 0};
        img[0] = 8'h7F; img[1] = 8'hB0; img[2] = 8'h90; img[3] = 8'hF0;
        load_mem(img);
        Run = 1'b1; tick(); Run = 1'b0;
        last = 0; k = 0;
        for (int t = 0; t < 40; t++) begin
            tick();
            if (int'(Pc) != last) begin
                chk("br_pc_seq", int'(Pc), br_seq[k % 4]);
                if (Pc == '0) begin
                    chk("br_acc", int'(Acc), 0);
                    chk("br_z", int'(FlagZ), 1);
                    chk("br_c", int'(FlagC), 1);
                end
                last = int'(Pc);
                k++;
            end
        end
        chk("br_iterations", int'(k >= 8), 1);
        chk("br_still_busy", int'(Busy), 1);
        chk("br_not_halted", int'(Halted), 0);
        StartStop = 1'b0; #1;
        chk_reset("rst_run");
        tick(); StartStop = 1'b1; tick();
        model_reset();

        // Reference program: LDI A, ADD M[B]=7, STA E, HLT.
        img = '{default: 0};
        img[0] = 8'h7A; img[1] = 8'h3B; img[2] = 8'h2E; img[3] = 8'hF0; img[11] = 8'h07;
        load_mem(img);
        run_prog(1);
        chk("ex_acc", int'(Acc), 1);
        chk("ex_cv", int'({FlagC, FlagV}), 2);
        chk("ex_pc", int'(Pc), 4);
        dump_check();

        // SUB borrow and SUB overflow.
        p = m_pc; d = (p + 8) % 16;
        img = '{default: 0};
        img[p] = 8'h73; img[(p + 1) % 16] = 8'h40 + d; img[(p + 2) % 16] = 8'hF0; img[d] = 8'h05;
        load_mem(img);
        run_prog(1);
        chk("sub_borrow_acc", int'(Acc), 14);
        chk("sub_borrow_cv", int'({FlagC, FlagV}), 2);
        p = m_pc; d = (p + 8) % 16;
        img = '{default: 0};
        img[p] = 8'h78; img[(p + 1) % 16] = 8'h40 + d; img[(p + 2) % 16] = 8'hF0; img[d] = 8'h01;
        load_mem(img);
        run_prog(1);
        chk("sub_ovf_acc", int'(Acc), 7);
        chk("sub_ovf_cv", int'({FlagC, FlagV}), 1);

        // Randomised programs, each guaranteed by the model to halt.
        for (int n = 0; n < 25; n++) begin
            ok = 0;
            for (int tr = 0; tr < 50 && !ok; tr++) begin
                for (int a = 0; a < 16; a++) begin
                    r = int'($urandom_range(0, 19));
                    op = (r > 15) ? 15 : r;
                    img[a] = op * 16 + int'($urandom_range(0, 15));
                end
                ok = model_halts(img);
            end
            if (!ok) img[m_pc] = 8'hF0;
            load_mem(img);
            run_prog(1);
            dump_check();
        end

        // Reset during STA's EXEC cycle must suppress the write.
        p = m_pc; d = (p + 8) % 16;
        img = '{default: 0};
        img[p] = 8'h79; img[(p + 1) % 16] = 8'h20 + d; img[d] = 8'h03;
        load_mem(img);
        Run = 1'b1; tick(); Run = 1'b0;
        tick(5);
        StartStop = 1'b0; #1;
        chk_reset("rst_sta");
        tick(); StartStop = 1'b1; tick();
        model_reset();
        dump_check();

`ifdef TRISC_STEP_EN
        // Single-step: FETCH holds without Step, each pulse retires one instruction.
        img = '{default: 0};
        img[0] = 8'hB0; img[1] = 8'hB0; img[2] = 8'hB0; img[3] = 8'hF0;
        load_mem(img);
        step_auto = 1'b0;
        push_expect(0);
        Run = 1'b1; tick(); Run = 1'b0;
        tick(20);
        chk("step_hold_pc", int'(Pc), 0);
        chk("step_hold_busy", int'(Busy), 1);
        for (int s = 0; s < 2; s++) begin
            step_man = 1'b1; tick(); step_man = 1'b0; tick(5);
        end
        chk("step_pc", int'(Pc), 2);
        chk("step_acc", int'(Acc), 2);
        step_auto = 1'b1;
        wait_empty(1000);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #800000;
        $display("FAIL watchdog expired (t=%0t)", $time);
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire
